// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by a word-addressed memory.
// Accepts one AR request at a time and returns arlen+1 beats on R.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   ar*                 read-address channel (arlock/arprot/arcache ignored)
//   r*                  read-data channel, all outputs registered
//   mem_we/addr/wdata   backdoor preload port into the memory
module axi_rd_responder #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int IDW   = 4,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IDW-1:0]           arid,
  input  logic [AW-1:0]            araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arlock,
  input  logic [2:0]               arprot,
  input  logic [3:0]               arcache,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [IDW-1:0]           rid,
  output logic [DW-1:0]            rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_addr,
  input  logic [DW-1:0]            mem_wdata
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  next_addr;

  logic           load_first, load_next;
  logic [AW-1:0]  src_addr;
  logic [2:0]     src_size;
  logic [1:0]     src_burst;
  logic [DW-1:0]  beat_data;
  logic [1:0]     beat_resp;

  logic [DW-1:0]  mem [DEPTH];

  logic           unused_ar;
  assign unused_ar = ^{arlock, arprot, arcache};

  assign arready = (state_q == IDLE) && !rst_i;
  assign rvalid  = (state_q == BURST);

  always_comb begin
    next_addr = addr_q;
    if (burst_q != BURST_FIXED) begin
      next_addr = addr_q + (AW'(1) << size_q);
    end
  end

  // Beat source: on AR acceptance the first beat is computed straight from the
  // AR inputs, later beats from the advanced address register.
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    src_addr   = addr_q;
    src_size   = size_q;
    src_burst  = burst_q;
    case (state_q)
      IDLE: begin
        if (arvalid && arready) begin
          state_d    = BURST;
          load_first = 1'b1;
          src_addr   = araddr;
          src_size   = arsize;
          src_burst  = arburst;
        end
      end
      BURST: begin
        if (rready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            load_next = 1'b1;
            src_addr  = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    beat_resp = RESP_OKAY;
    beat_data = mem[src_addr[IW+1:2]];
    if (src_burst[1] || (src_size > 3'd2)) begin
      beat_resp = RESP_SLVERR;
      beat_data = '0;
    end else if (src_addr[AW-1:2] >= (AW-2)'(DEPTH)) begin
      beat_resp = RESP_DECERR;
      beat_data = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_first) begin
        rid     <= arid;
        cnt_q   <= arlen;
        size_q  <= arsize;
        burst_q <= arburst;
        rlast   <= (arlen == 8'd0);
      end
      if (load_next) begin
        cnt_q <= cnt_q - 8'd1;
        rlast <= (cnt_q == 8'd1);
      end
      if (load_first || load_next) begin
        addr_q <= src_addr;
        rdata  <= beat_data;
        rresp  <= beat_resp;
      end
    end
  end

  // Not reset; a same-edge write leaves rdata with the old word.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
module tb_axi_rd_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arlock = 1'b0;
  logic [2:0]  arprot = '0;
  logic [3:0]  arcache = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;

  logic [31:0] ref_mem [DEPTH];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_rd_responder #(.AW(32), .DW(32), .IDW(4), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arprot(arprot), .arcache(arcache),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: beat i address is start (FIXED) or start + i*bytes (INCR).
  task automatic exp_beat(input logic [31:0] addr, input int i, input logic [2:0] size,
                          input logic [1:0] burst, output logic [31:0] data,
                          output logic [1:0] resp);
    logic [31:0] a;
    a = (burst == 2'b00) ? addr : addr + 32'(i) * (32'd1 << size);
    if (burst >= 2'd2 || size > 3'd2) begin
      resp = 2'b10;
      data = '0;
    end else if (a >= 32'(DEPTH * 4)) begin
      resp = 2'b11;
      data = '0;
    end else begin
      resp = 2'b00;
      data = ref_mem[a >> 2];
    end
  endtask

  task automatic mem_wr(input int w, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_addr  = 10'(w);
    mem_wdata = d;
    ref_mem[w] = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arlock = 1'($urandom_range(0, 1)); arprot = 3'($urandom_range(0, 7));
    arcache = 4'($urandom_range(0, 15));
    arvalid = 1'b1;
    for (int k = 0; k < 50 && arready !== 1'b1; k++) @(negedge clk);
    check("ar_accept", arready, 1);
  endtask

  // Entered at the negedge after the AR handshake; returns at the negedge
  // after the last R handshake (or after an injected reset).
  task automatic r_collect(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit bp,
                           input int abort_at);
    int beat = 0;
    int cyc = 0;
    logic [31:0] ed;
    logic [1:0]  er;
    while (beat <= int'(len) && cyc < 600) begin
      if (beat == abort_at) begin
        rready = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_arready", arready, 0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_rel_arready", arready, 1);
        check("rst_rel_rvalid", rvalid, 0);
        @(negedge clk);
        check("rst_no_beats", rvalid, 0);
        return;
      end
      rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      exp_beat(addr, beat, size, burst, ed, er);
      check("rvalid", rvalid, 1);
      check("arready_busy", arready, 0);
      check("rid", rid, id);
      check("rdata", rdata, ed);
      check("rresp", rresp, er);
      check("rlast", rlast, (beat == int'(len)) ? 1 : 0);
      if (rvalid && rready) beat++;
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    check("beats_done", beat, int'(len) + 1);
    if (!bp) check("throughput_cycles", cyc, int'(len) + 1);
  endtask

  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input bit bp);
    ar_issue(id, addr, len, size, bt);
    @(negedge clk);
    arvalid = 1'b0;
    r_collect(id, addr, len, size, bt, bp, -1);
    check("turn_arready", arready, 1);
    check("turn_rvalid", rvalid, 0);
  endtask

  initial begin
    #2;
    rst_i = 1'b1;
    #2;
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_arready", arready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("rst_release_arready", arready, 1);
    @(negedge clk);

    for (int w = 0; w < 128; w++) mem_wr(w, $urandom);
    mem_wr(1022, $urandom);
    mem_wr(1023, $urandom);

    // Single beat
    mem_wr(4, 32'hDEADBEEF);
    burst(4'd5, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);

    // INCR burst with random backpressure
    for (int i = 0; i < 8; i++) mem_wr(i, 32'(i));
    burst(4'd3, 32'h0, 8'd7, 3'd2, 2'b01, 1'b1);

    // FIXED, and narrow INCR
    burst(4'd1, 32'h8, 8'd3, 3'd2, 2'b00, 1'b0);
    burst(4'd2, 32'h0, 8'd7, 3'd0, 2'b01, 1'b0);

    // Error responses
    burst(4'd4, 32'h40, 8'd3, 3'd2, 2'b10, 1'b0);
    burst(4'd6, 32'h0, 8'd1, 3'd3, 2'b01, 1'b0);
    burst(4'd7, 32'h0, 8'd0, 3'd2, 2'b11, 1'b0);
    burst(4'd9, 32'hFF8, 8'd3, 3'd2, 2'b01, 1'b0);

    // Reset during beat 3 of an 8-beat burst, then a fresh request
    ar_issue(4'd10, 32'h20, 8'd7, 3'd2, 2'b01);
    @(negedge clk);
    arvalid = 1'b0;
    r_collect(4'd10, 32'h20, 8'd7, 3'd2, 2'b01, 1'b0, 3);
    burst(4'd11, 32'h24, 8'd2, 3'd2, 2'b01, 1'b0);

    // Back-to-back with arvalid held high
    ar_issue(4'd1, 32'h0, 8'd3, 3'd2, 2'b01);
    @(negedge clk);
    arid = 4'd2; araddr = 32'h30; arlen = 8'd2; arsize = 3'd2; arburst = 2'b01;
    r_collect(4'd1, 32'h0, 8'd3, 3'd2, 2'b01, 1'b0, -1);
    check("b2b_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    r_collect(4'd2, 32'h30, 8'd2, 3'd2, 2'b01, 1'b0, -1);
    check("b2b_turn_rvalid", rvalid, 0);

    // Backdoor write to the word being loaded on the same edge
    arid = 4'd12; araddr = 32'h20; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    mem_we = 1'b1; mem_addr = 10'd8; mem_wdata = 32'hA5A50F0F;
    check("hazard_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    mem_we = 1'b0;
    r_collect(4'd12, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, -1);
    ref_mem[8] = 32'hA5A50F0F;
    burst(4'd13, 32'h20, 8'd0, 3'd2, 2'b01, 1'b0);

    // Randomized bursts
    for (int t = 0; t < 20; t++) begin
      burst(4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)), 8'($urandom_range(0, 15)),
            3'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI4 read-channel responder (slave) for the testbench bus: it accepts read-address requests on AR and returns single or burst read data on R from an internal word-addressed memory. Its width parameters match the bus parameter package: 32-bit address, 32-bit data, 4-bit ID and 3-bit size. It is the far end of the bus master's read path and is preloaded through a simple backdoor write port.

## Interface
- AW, 32, address width (BUS_AW)
- DW, 32, data width (BUS_DW); fixed at 32 for this block
- IDW, 4, ID width (BUS_IDW)
- DEPTH, 1024, memory depth in DW-bit words; valid byte range is 0 to DEPTH*4-1
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- arid  in  IDW  request ID
- araddr  in  AW  start byte address
- arlen  in  8  beats minus 1
- arsize  in  3  bytes per beat = 1<<arsize
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlock  in  1  accepted and ignored
- arprot  in  3  accepted and ignored
- arcache  in  4  accepted and ignored
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  IDW  echoed arid
- rdata  out  DW  read data
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- rlast  out  1  last beat of the burst
- rvalid  out  1  R valid
- rready  in  1  R ready
- mem_we  in  1  backdoor write enable
- mem_addr  in  $clog2(DEPTH)  backdoor word index
- mem_wdata  in  DW  backdoor write data

## Operation
- FSM with two states: IDLE and BURST.
- **IDLE**
  - arready=1, rvalid=0.
  - An AR handshake (arvalid && arready) latches arid, arlen, arsize and arburst, and sets the address register to araddr.
  - The same handshake loads the first beat into the R registers and moves to BURST.
- **BURST**
  - arready=0 and rvalid=1.
  - On each R handshake (rvalid && rready) that is not the last beat: decrement the beat counter, advance the address, and load the next beat.
  - On the last-beat handshake: go to IDLE.
  - If rready is low, rid, rdata, rresp and rlast hold stable.
- Only one burst is outstanding at a time. No AR is accepted during BURST.
- **Beat count:** 8-bit remaining-beat counter, loaded with arlen. rlast=1 when the counter is 0, so an arlen=0 burst has a single beat with rlast=1.
- **Address advance:**
  - FIXED: address unchanged.
  - INCR: address += 1<<arsize, modulo 2^AW. There is no 4 KB boundary check.
- **Beat data:** memory word at address[AW-1:2]. The full aligned word is always returned; the master selects byte lanes for narrow transfers.
- **Response per beat, in priority order:**
  - arburst is WRAP or reserved, or arsize>2: SLVERR with rdata=0 for every beat. The full arlen+1 beats are still returned.
  - Beat address >= DEPTH*4: DECERR with rdata=0. This is evaluated per beat, so a burst that runs past the top of memory switches from OKAY to DECERR mid-burst.
  - Otherwise: OKAY. arlock=1 also returns OKAY; EXOKAY is never returned.
- **Backdoor:** when mem_we=1, mem[mem_addr] <= mem_wdata. If the write hits the word being loaded into rdata in the same cycle, rdata captures the pre-write value.
- The memory is not cleared by reset.

## Timing
- **Reset** (asynchronous, immediate):
  - State goes to IDLE.
  - rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, counter=0.
  - arready=0 while rst_i=1, and 1 in the first cycle after deassertion.
- **Reset mid-burst:** the burst is abandoned, rvalid drops in the same cycle, and no further beats are sent after release.
- **Latency:** AR handshake in cycle N gives rvalid=1 with beat 0 in cycle N+1.
- **Throughput:** with rready held high, one beat per cycle. A burst of arlen+1 beats completes in cycle N+1+arlen.
- **Turnaround:** after the last-beat handshake in cycle M, arready=1 in cycle M+1. The earliest next AR handshake is M+1, and the earliest next rvalid is M+2.
- arready is driven combinationally from state only (no input-to-output combinational path). All R outputs are registered.

## Test plan
- **Single beat:** preload mem[4]=0xDEADBEEF; AR araddr=0x10, arlen=0, arsize=2, INCR, arid=5 -> one beat in the next cycle: rdata=0xDEADBEEF, rid=5, rresp=OKAY, rlast=1; arready returns the cycle after.
- **INCR burst with backpressure:** mem[i]=i for i=0..7; AR araddr=0, arlen=7, arsize=2; toggle rready randomly -> rdata sequence 0..7, outputs stable while stalled, rlast only on beat 8.
- **FIXED and narrow beats:**
  - FIXED, araddr=0x8, arlen=3 -> four beats, all mem[2].
  - INCR, arsize=0, araddr=0, arlen=7 -> mem[0] ×4 then mem[1] ×4.
- **Error responses:**
  - WRAP with arlen=3 -> four SLVERR beats with rdata=0.
  - arsize=3 -> SLVERR.
  - DEPTH=1024, INCR at araddr=0xFF8, arlen=3 -> OKAY, OKAY, DECERR, DECERR.
- **Reset mid-burst:** assert rst_i during beat 3 of an arlen=7 burst -> rvalid=0 immediately, arready=1 after release, and a new AR returns correct data.
- **Back-to-back:** two ARs with arvalid held high (IDs 1 and 2) -> second accepted the cycle after the first rlast handshake, rid=2 on its beats, no beat loss or duplication.
